// File: rtl/rv32i_writeback.sv
// RV32I writeback stage: retires ALU results directly and waits for data memory on loads.
// Optional retired-instruction counter enabled by defining RV32I_WB_INSTRET_EN.
module rv32i_writeback (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic        in_rd_we,
  input  logic        in_is_load,
  input  logic [2:0]  in_funct3,
  input  logic [1:0]  in_addr_lo,
  input  logic [31:0] in_result,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rsp_data,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic        reg_write_enable,
  output logic        retire,
  output logic        busy,
  output logic [31:0] instret
);
  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  state_t           state, state_next;
  logic [REG_W-1:0] ld_rd, ld_rd_next;
  logic             ld_we, ld_we_next;
  logic [2:0]       ld_funct3, ld_funct3_next;
  logic [1:0]       ld_addr_lo, ld_addr_lo_next;
  logic [REG_W-1:0] write_reg_next;
  logic [XLEN-1:0]  write_data_next;
  logic             reg_write_enable_next;
  logic             retire_next;
  logic             accept;

  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign busy     = (state == WAIT_LOAD);

  // Byte/halfword lane select and extension; unknown funct3 codes behave as LW.
  function automatic logic [XLEN-1:0] load_extract(input logic [2:0] funct3,
                                                   input logic [1:0] addr_lo,
                                                   input logic [XLEN-1:0] word);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    case (addr_lo)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  return {{24{byte_sel[7]}}, byte_sel};
      3'b100:  return {24'd0, byte_sel};
      3'b001:  return {{16{half_sel[15]}}, half_sel};
      3'b101:  return {16'd0, half_sel};
      default: return word;
    endcase
  endfunction

  always_comb begin
    state_next            = state;
    ld_rd_next            = ld_rd;
    ld_we_next            = ld_we;
    ld_funct3_next        = ld_funct3;
    ld_addr_lo_next       = ld_addr_lo;
    write_reg_next        = write_reg;
    write_data_next       = write_data;
    reg_write_enable_next = 1'b0;
    retire_next           = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (in_is_load) begin
            ld_rd_next      = in_rd;
            ld_we_next      = in_rd_we;
            ld_funct3_next  = in_funct3;
            ld_addr_lo_next = in_addr_lo;
            state_next      = WAIT_LOAD;
          end else begin
            write_reg_next        = in_rd;
            write_data_next       = in_result;
            reg_write_enable_next = in_rd_we && (in_rd != REG_W'(0));
            retire_next           = 1'b1;
          end
        end
      end
      WAIT_LOAD: begin
        if (dmem_rsp_valid) begin
          write_reg_next        = ld_rd;
          write_data_next       = load_extract(ld_funct3, ld_addr_lo, dmem_rsp_data);
          reg_write_enable_next = ld_we && (ld_rd != REG_W'(0));
          retire_next           = 1'b1;
          state_next            = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      ld_rd            <= '0;
      ld_we            <= 1'b0;
      ld_funct3        <= '0;
      ld_addr_lo       <= '0;
      write_reg        <= '0;
      write_data       <= '0;
      reg_write_enable <= 1'b0;
      retire           <= 1'b0;
    end else begin
      state            <= state_next;
      ld_rd            <= ld_rd_next;
      ld_we            <= ld_we_next;
      ld_funct3        <= ld_funct3_next;
      ld_addr_lo       <= ld_addr_lo_next;
      write_reg        <= write_reg_next;
      write_data       <= write_data_next;
      reg_write_enable <= reg_write_enable_next;
      retire           <= retire_next;
    end
  end

`ifdef RV32I_WB_INSTRET_EN
  logic [XLEN-1:0] instret_q;

  // Counts on the same edge that registers retire; wraps naturally.
  always_ff @(posedge clk) begin
    if (rst)              instret_q <= '0;
    else if (retire_next) instret_q <= instret_q + XLEN'(1);
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_rv32i_writeback.sv
// Scoreboard bench for rv32i_writeback: expected writebacks queued at issue, checked at retire.
module tb_rv32i_writeback;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_rd_we;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_result;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_data;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        reg_write_enable;
  logic        retire;
  logic        busy;
  logic [31:0] instret;

  rv32i_writeback dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_rd_we(in_rd_we),
    .in_is_load(in_is_load), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo), .in_result(in_result),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_data(dmem_rsp_data),
    .write_reg(write_reg), .write_data(write_data), .reg_write_enable(reg_write_enable),
    .retire(retire), .busy(busy), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
  } wb_t;

  wb_t         sb[$];
  wb_t         exp;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_instret = '0;
  logic [4:0]  last_rd = '0;
  logic [31:0] last_data = '0;

  task automatic bump_instret();
`ifdef RV32I_WB_INSTRET_EN
    exp_instret = exp_instret + 32'd1;
`endif
  endtask

  task automatic drive(input logic [4:0] rd, input logic we, input logic ld,
                       input logic [2:0] f3, input logic [1:0] a, input logic [31:0] res);
    in_valid = 1'b1; in_rd = rd; in_rd_we = we; in_is_load = ld;
    in_funct3 = f3; in_addr_lo = a; in_result = res;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || write_reg !== 5'd0 || write_data !== 32'd0 || reg_write_enable !== 1'b0 ||
        retire !== 1'b0 || busy !== 1'b0 || instret !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: ready=%b rd=%0d data=%h we=%b retire=%b busy=%b instret=%0d, expected all 0",
               in_ready, write_reg, write_data, reg_write_enable, retire, busy, instret);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b busy=%b, expected ready=1 busy=0", in_ready, busy);
    end
  endtask

  task automatic test_non_load();
    @(posedge clk); #1;
    drive(5'd5, 1'b1, 1'b0, 3'd0, 2'd0, 32'hDEADBEEF);
    sb.push_back(wb_t'{rd: 5'd5, data: 32'hDEADBEEF, we: 1'b1});
    bump_instret();
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    exp = sb.pop_front();
    checks++;
    if (retire !== 1'b1 || reg_write_enable !== exp.we || write_reg !== exp.rd || write_data !== exp.data ||
        instret !== exp_instret) begin
      errors++;
      $display("FAIL nonload_wb: retire=%b we=%b rd=%0d data=%h instret=%0d, expected retire=1 we=%b rd=%0d data=%h instret=%0d",
               retire, reg_write_enable, write_reg, write_data, instret, exp.we, exp.rd, exp.data, exp_instret);
    end
    last_rd = exp.rd; last_data = exp.data;
    @(negedge clk);
    checks++;
    if (retire !== 1'b0 || reg_write_enable !== 1'b0 || write_reg !== last_rd || write_data !== last_data) begin
      errors++;
      $display("FAIL nonload_hold: retire=%b we=%b rd=%0d data=%h, expected retire=0 we=0 rd=%0d data=%h",
               retire, reg_write_enable, write_reg, write_data, last_rd, last_data);
    end
  endtask

  // Loads from a table; wait cycles between accept and response vary per entry.
  task automatic test_loads();
    logic [2:0]  f3   [8] = '{3'b000, 3'b101, 3'b001, 3'b100, 3'b000, 3'b010, 3'b011, 3'b001};
    logic [1:0]  ad   [8] = '{2'd3, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd2, 2'd0};
    logic [31:0] word [8] = '{32'h80FF1234, 32'h9ABC1234, 32'h9ABC1234, 32'h80FF1234,
                              32'h80FF1234, 32'hCAFEF00D, 32'h13572468, 32'h00008001};
    logic [31:0] res  [8] = '{32'hFFFFFF80, 32'h00009ABC, 32'hFFFF9ABC, 32'h00000080,
                              32'hFFFFFFFF, 32'hCAFEF00D, 32'h13572468, 32'hFFFF8001};
    int          waits[8] = '{2, 0, 1, 0, 1, 2, 0, 1};
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      drive(5'(i + 7), 1'b1, 1'b1, f3[i], ad[i], 32'h0BAD0BAD);
      sb.push_back(wb_t'{rd: 5'(i + 7), data: res[i], we: 1'b1});
      bump_instret();
      @(posedge clk); #1 in_valid = 1'b0;
      for (int w = 0; w < waits[i]; w++) begin
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1 || retire !== 1'b0) begin
          errors++;
          $display("FAIL load_wait[%0d]: ready=%b busy=%b retire=%b, expected ready=0 busy=1 retire=0",
                   i, in_ready, busy, retire);
        end
        @(posedge clk); #1;
      end
      dmem_rsp_valid = 1'b1; dmem_rsp_data = word[i];
      @(posedge clk); #1 dmem_rsp_valid = 1'b0; dmem_rsp_data = 32'h0;
      @(negedge clk);
      exp = sb.pop_front();
      checks++;
      if (retire !== 1'b1 || reg_write_enable !== exp.we || write_reg !== exp.rd || write_data !== exp.data ||
          in_ready !== 1'b1 || busy !== 1'b0 || instret !== exp_instret) begin
        errors++;
        $display("FAIL load_wb[%0d]: retire=%b we=%b rd=%0d data=%h ready=%b busy=%b instret=%0d, expected retire=1 we=%b rd=%0d data=%h ready=1 busy=0 instret=%0d",
                 i, retire, reg_write_enable, write_reg, write_data, in_ready, busy, instret,
                 exp.we, exp.rd, exp.data, exp_instret);
      end
      last_rd = exp.rd; last_data = exp.data;
      @(negedge clk);
      checks++;
      if (retire !== 1'b0 || reg_write_enable !== 1'b0 || write_data !== last_data) begin
        errors++;
        $display("FAIL load_pulse[%0d]: retire=%b we=%b data=%h, expected retire=0 we=0 data=%h",
                 i, retire, reg_write_enable, write_data, last_data);
      end
    end
  endtask

  task automatic test_not_ready();
    @(posedge clk); #1;
    drive(5'd9, 1'b1, 1'b1, 3'b010, 2'd0, 32'h0);
    sb.push_back(wb_t'{rd: 5'd9, data: 32'h600DF00D, we: 1'b1});
    bump_instret();
    @(posedge clk); #1;
    drive(5'd10, 1'b1, 1'b0, 3'd0, 2'd0, 32'h55555555);
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (retire !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL not_ready_ignore: retire=%b ready=%b, expected retire=0 ready=0", retire, in_ready);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    dmem_rsp_valid = 1'b1; dmem_rsp_data = 32'h600DF00D;
    @(posedge clk); #1 dmem_rsp_valid = 1'b0;
    @(negedge clk);
    exp = sb.pop_front();
    checks++;
    if (retire !== 1'b1 || write_reg !== exp.rd || write_data !== exp.data || reg_write_enable !== exp.we) begin
      errors++;
      $display("FAIL not_ready_wb: retire=%b rd=%0d data=%h we=%b, expected retire=1 rd=%0d data=%h we=%b",
               retire, write_reg, write_data, reg_write_enable, exp.rd, exp.data, exp.we);
    end
    last_rd = exp.rd; last_data = exp.data;
    @(negedge clk);
    checks++;
    if (retire !== 1'b0 || instret !== exp_instret) begin
      errors++;
      $display("FAIL not_ready_extra: retire=%b instret=%0d, expected retire=0 instret=%0d",
               retire, instret, exp_instret);
    end
  endtask

  task automatic test_idle_rsp();
    @(posedge clk); #1 dmem_rsp_valid = 1'b1; dmem_rsp_data = 32'hFFFFFFFF;
    @(posedge clk); #1 dmem_rsp_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (retire !== 1'b0 || reg_write_enable !== 1'b0 || write_reg !== last_rd || write_data !== last_data ||
          busy !== 1'b0 || instret !== exp_instret) begin
        errors++;
        $display("FAIL idle_rsp: retire=%b we=%b rd=%0d data=%h busy=%b instret=%0d, expected 0 0 %0d %h 0 %0d",
                 retire, reg_write_enable, write_reg, write_data, busy, instret, last_rd, last_data, exp_instret);
      end
    end
  endtask

  task automatic test_rd_zero();
    logic [4:0]  rd [3] = '{5'd0, 5'd3, 5'd0};
    logic        we [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] r  [3] = '{32'h1, 32'h33, 32'h44};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive(rd[i], we[i], 1'b0, 3'd0, 2'd0, r[i]);
      sb.push_back(wb_t'{rd: rd[i], data: r[i], we: 1'b0});
      bump_instret();
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      exp = sb.pop_front();
      checks++;
      if (retire !== 1'b1 || reg_write_enable !== exp.we || write_reg !== exp.rd || write_data !== exp.data ||
          instret !== exp_instret) begin
        errors++;
        $display("FAIL rd_zero[%0d]: retire=%b we=%b rd=%0d data=%h instret=%0d, expected retire=1 we=0 rd=%0d data=%h instret=%0d",
                 i, retire, reg_write_enable, write_reg, write_data, instret, exp.rd, exp.data, exp_instret);
      end
      last_rd = exp.rd; last_data = exp.data;
    end
  endtask

  task automatic test_reset_in_wait();
    @(posedge clk); #1;
    drive(5'd4, 1'b1, 1'b1, 3'b010, 2'd0, 32'h0);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_wait_busy: busy=%b, expected 1", busy);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_ready: ready=%b, expected 0", in_ready);
    end
    @(posedge clk); #1 rst = 1'b0;
    sb.delete(); exp_instret = '0; last_rd = '0; last_data = '0;
    dmem_rsp_valid = 1'b1; dmem_rsp_data = 32'h12345678;
    @(posedge clk); #1 dmem_rsp_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (retire !== 1'b0 || reg_write_enable !== 1'b0 || instret !== 32'd0 || in_ready !== 1'b1 ||
          busy !== 1'b0 || write_data !== 32'd0 || write_reg !== 5'd0) begin
        errors++;
        $display("FAIL rst_drop_load: retire=%b we=%b instret=%0d ready=%b busy=%b rd=%0d data=%h, expected 0 0 0 1 0 0 0",
                 retire, reg_write_enable, instret, in_ready, busy, write_reg, write_data);
      end
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    drive(5'd1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h100);
    sb.push_back(wb_t'{rd: 5'd1, data: 32'h100, we: 1'b1});
    bump_instret();
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (i < 4) begin
        drive(5'(i + 1), 1'b1, 1'b0, 3'd0, 2'd0, 32'h100 + 32'(i));
        sb.push_back(wb_t'{rd: 5'(i + 1), data: 32'h100 + 32'(i), we: 1'b1});
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      exp = sb.pop_front();
      checks++;
      if (retire !== 1'b1 || reg_write_enable !== exp.we || write_reg !== exp.rd || write_data !== exp.data ||
          in_ready !== 1'b1 || instret !== exp_instret) begin
        errors++;
        $display("FAIL b2b[%0d]: retire=%b we=%b rd=%0d data=%h ready=%b instret=%0d, expected 1 %b %0d %h 1 %0d",
                 i, retire, reg_write_enable, write_reg, write_data, in_ready, instret,
                 exp.we, exp.rd, exp.data, exp_instret);
      end
      if (i < 4) bump_instret();
    end
    @(negedge clk);
    checks++;
`ifdef RV32I_WB_INSTRET_EN
    if (retire !== 1'b0 || instret !== 32'd4) begin
      errors++;
      $display("FAIL b2b_instret: retire=%b instret=%0d, expected retire=0 instret=4", retire, instret);
    end
`else
    if (retire !== 1'b0 || instret !== 32'd0) begin
      errors++;
      $display("FAIL b2b_instret: retire=%b instret=%0d, expected retire=0 instret=0", retire, instret);
    end
`endif
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_rd_we = 1'b0; in_is_load = 1'b0;
    in_funct3 = '0; in_addr_lo = '0; in_result = '0; dmem_rsp_valid = 1'b0; dmem_rsp_data = '0;
    test_reset();
    test_non_load();
    test_loads();
    test_not_ready();
    test_idle_rsp();
    test_rd_zero();
    test_reset_in_wait();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_writeback.md
RV32I_WRITEBACK -- requirements
Module: rv32i_writeback

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk input 1 (all state on rising edge); rst input 1 (synchronous, active-high).
REQ-002 SHALL have upstream ports: in_valid input 1 (instruction offered); in_ready output 1 (stage can accept); in_rd input 5 (destination register); in_rd_we input 1 (instruction writes rd); in_is_load input 1 (result comes from data memory); in_funct3 input 3 (load type); in_addr_lo input 2 (load address bits [1:0]); in_result input 32 (ALU/PC+4 result).
REQ-003 SHALL have data-memory ports: dmem_rsp_valid input 1 (load data present, one-cycle pulse); dmem_rsp_data input 32 (aligned 32-bit word).
REQ-004 SHALL have register-file ports: write_reg output 5; write_data output 32; reg_write_enable output 1.
REQ-005 SHALL have status ports: retire output 1 (one-cycle pulse per completed instruction); busy output 1 (load outstanding); instret output 32 (retired count).

Function
REQ-006 SHALL implement states IDLE and WAIT_LOAD; in_ready SHALL be 1 exactly when state is IDLE and rst is 0.
REQ-007 SHALL accept on a rising edge where in_valid and in_ready are both 1; without in_ready, inputs SHALL be ignored.
REQ-008 Non-load accept at edge N: write_reg, write_data=in_result, reg_write_enable and retire SHALL be registered and valid for exactly cycle N+1; state stays IDLE.
REQ-009 Back-to-back non-load instructions SHALL be accepted every cycle (throughput 1/cycle).
REQ-010 Load accept at edge N: SHALL latch in_rd, in_rd_we, in_funct3, in_addr_lo; go to WAIT_LOAD; busy=1 from cycle N+1.
REQ-011 In WAIT_LOAD, edge M with dmem_rsp_valid=1: SHALL register the extracted load value and assert reg_write_enable/retire for cycle M+1 only; return to IDLE (in_ready=1 in cycle M+1).
REQ-012 Load extraction: funct3 000 LB = sign-extended byte selected by addr_lo; 100 LBU = zero-extended same byte; 001 LH = sign-extended halfword selected by addr_lo[1]; 101 LHU = zero-extended same; 010 LW = full word.
REQ-013 addr_lo[0] SHALL be ignored for LH/LHU; addr_lo SHALL be ignored for LW; funct3 011/110/111 SHALL be treated as LW.
REQ-014 reg_write_enable SHALL be 0 when rd_we=0 or rd=0; retire SHALL still pulse; write_reg/write_data SHALL still update.
REQ-015 dmem_rsp_valid in IDLE SHALL be ignored with no output change.
REQ-016 When reg_write_enable/retire are not pulsing, they SHALL be 0 and write_reg/write_data SHALL hold their last value.
REQ-017 instret SHALL increment by 1 on each edge after which retire is asserted; it SHALL wrap from 0xFFFFFFFF to 0.

Reset
REQ-018 rst=1 at an edge SHALL force state IDLE and clear write_reg, write_data, reg_write_enable, retire, busy and instret to 0.
REQ-019 Reset in WAIT_LOAD SHALL drop the pending load; a dmem_rsp_valid arriving after reset SHALL be ignored per REQ-015.
REQ-020 in_ready SHALL be 0 during any cycle rst=1.

Configuration
REQ-021 Macro RV32I_WB_INSTRET_EN defined: instret counter per REQ-017 is present.
REQ-022 Macro RV32I_WB_INSTRET_EN undefined: no counter register; instret SHALL be constant 0; all other behaviour identical.

Verification
REQ-023 Non-load: in_rd=5, in_rd_we=1, in_result=0xDEADBEEF accepted at edge N -> cycle N+1: reg_write_enable=1, write_reg=5, write_data=0xDEADBEEF, retire=1; cycle N+2 reg_write_enable=0.
REQ-024 LB, addr_lo=3; response 0x80FF1234 after 2 wait cycles -> in_ready=0 and busy=1 while waiting; write_data=0xFFFFFF80 for one cycle; then in_ready=1.
REQ-025 LHU addr_lo=2 and LH addr_lo=3, data 0x9ABC1234 -> write_data 0x00009ABC, then 0xFFFF9ABC.
REQ-026 in_rd=0, in_rd_we=1, result 0x1 -> reg_write_enable=0, retire=1, instret increments by 1.
REQ-027 Reset asserted in WAIT_LOAD, dmem_rsp_valid pulsed after reset -> no reg_write_enable, instret=0, state IDLE, in_ready=1.
REQ-028 Four back-to-back non-loads with macro defined -> four consecutive reg_write_enable cycles, instret=4; macro undefined -> instret stays 0.
